// File: rtl/mat_sum_seq.sv
// mat_sum_seq
// Sums every element of a ROWS x COLS signed fixed-point matrix into one
// saturated scalar, one element per clock, using a single adder. It sits
// directly after the element-wise square stage, so together they give the
// squared Frobenius norm. The sum is scale-preserving, so no fraction-bit
// parameter is needed here.
//
// Ports:
//   clk_i    clock
//   rst_ni   asynchronous active-low reset
//   start_i  single-cycle request; accepted only while idle
//   a_i      [ROWS:1][COLS:1][WIDTH-1:0] signed matrix, sampled on acceptance
//   busy_o   high while a sum is in progress (ACC or DONE)
//   done_o   one-cycle pulse marking f_o/ovf_o valid
//   f_o      signed saturated sum, held until the next completion
//   ovf_o    sum was saturated, updates with f_o

module mat_sum_seq #(
  parameter int ROWS  = 1,
  parameter int COLS  = 1,
  parameter int WIDTH = 16
) (
  input  logic                             clk_i,
  input  logic                             rst_ni,
  input  logic                             start_i,
  input  logic [ROWS:1][COLS:1][WIDTH-1:0] a_i,
  output logic                             busy_o,
  output logic                             done_o,
  output logic [WIDTH-1:0]                 f_o,
  output logic                             ovf_o
);

  localparam int N  = ROWS * COLS;
  // Enough headroom that N full-scale elements can never wrap the accumulator.
  localparam int AW = WIDTH + $clog2(N) + 1;
  localparam int RW = $clog2(ROWS + 1);
  localparam int CW = $clog2(COLS + 1);

  localparam logic [RW-1:0] LAST_ROW = RW'(ROWS);
  localparam logic [CW-1:0] LAST_COL = CW'(COLS);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t                           state_q, state_d;
  logic [ROWS:1][COLS:1][WIDTH-1:0] snap_q, snap_d;
  logic signed [AW-1:0]             acc_q, acc_d;
  logic [RW-1:0]                    row_q, row_d;
  logic [CW-1:0]                    col_q, col_d;
  logic [WIDTH-1:0]                 f_q, f_d;
  logic                             ovf_q, ovf_d;
  logic                             done_q, done_d;

  logic [WIDTH-1:0]                 elem;
  logic signed [AW-1:0]             elem_ext;
  logic signed [AW-1:0]             sum;
  logic [AW-WIDTH:0]                sum_top;
  logic                             sat_ovf;
  logic [WIDTH-1:0]                 sat_f;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      snap_q  <= '0;
      acc_q   <= '0;
      row_q   <= RW'(1);
      col_q   <= CW'(1);
      f_q     <= '0;
      ovf_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      snap_q  <= snap_d;
      acc_q   <= acc_d;
      row_q   <= row_d;
      col_q   <= col_d;
      f_q     <= f_d;
      ovf_q   <= ovf_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    snap_d  = snap_q;
    acc_d   = acc_q;
    row_d   = row_q;
    col_d   = col_q;
    f_d     = f_q;
    ovf_d   = ovf_q;
    done_d  = 1'b0;

    elem     = snap_q[row_q][col_q];
    elem_ext = {{(AW-WIDTH){elem[WIDTH-1]}}, elem};
    sum      = acc_q + elem_ext;

    // The sum fits in WIDTH bits only when every bit from the WIDTH-1 sign
    // position upward agrees; otherwise clamp toward the sign of the sum.
    sum_top = sum[AW-1:WIDTH-1];
    sat_ovf = !((&sum_top) || (~|sum_top));
    if (sat_ovf) begin
      sat_f = sum[AW-1] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
    end else begin
      sat_f = sum[WIDTH-1:0];
    end

    case (state_q)
      IDLE: begin
        if (start_i) begin
          snap_d  = a_i;
          acc_d   = '0;
          row_d   = RW'(1);
          col_d   = CW'(1);
          state_d = ACC;
        end
      end
      ACC: begin
        acc_d = sum;
        if (col_q == LAST_COL) begin
          col_d = CW'(1);
          if (row_q == LAST_ROW) begin
            // Final element: result registers now so it is visible in DONE.
            row_d   = RW'(1);
            f_d     = sat_f;
            ovf_d   = sat_ovf;
            done_d  = 1'b1;
            state_d = DONE;
          end else begin
            row_d = row_q + RW'(1);
          end
        end else begin
          col_d = col_q + CW'(1);
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign busy_o = (state_q != IDLE);
  assign done_o = done_q;
  assign f_o    = f_q;
  assign ovf_o  = ovf_q;

endmodule

// File: tb/tb_mat_sum_seq.sv
// tb_mat_sum_seq
// Directed bench for mat_sum_seq with three instances (2x2, 3x1, 1x1, all
// 16-bit) sharing one clock and reset. Each scenario task drives its own
// stimulus and compares against hand-computed values.

module tb_mat_sum_seq;

  logic clk;
  logic rst_n;

  logic                   start22, busy22, done22, ovf22;
  logic [2:1][2:1][15:0]  a22;
  logic [15:0]            f22;

  logic                   start31, busy31, done31, ovf31;
  logic [3:1][1:1][15:0]  a31;
  logic [15:0]            f31;

  logic                   start11, busy11, done11, ovf11;
  logic [1:1][1:1][15:0]  a11;
  logic [15:0]            f11;

  int checks = 0;
  int passes = 0;

  // Saturation vectors in row-major order with their expected results.
  int satVec [6][4] = '{
    '{ 20000,  20000,  20000,  20000},
    '{-20000, -20000, -20000, -20000},
    '{ 16000,  16000,    767,      0},
    '{ 16384,  16384,      0,      0},
    '{-16384, -16384,      0,      0},
    '{-16384, -16384,     -1,      0}
  };
  int satExpF   [6] = '{32767, -32768, 32767, 32767, -32768, -32768};
  int satExpOvf [6] = '{1, 1, 0, 1, 0, 1};

  mat_sum_seq #(.ROWS(2), .COLS(2), .WIDTH(16)) dut22 (
    .clk_i(clk), .rst_ni(rst_n), .start_i(start22), .a_i(a22),
    .busy_o(busy22), .done_o(done22), .f_o(f22), .ovf_o(ovf22)
  );

  mat_sum_seq #(.ROWS(3), .COLS(1), .WIDTH(16)) dut31 (
    .clk_i(clk), .rst_ni(rst_n), .start_i(start31), .a_i(a31),
    .busy_o(busy31), .done_o(done31), .f_o(f31), .ovf_o(ovf31)
  );

  mat_sum_seq #(.ROWS(1), .COLS(1), .WIDTH(16)) dut11 (
    .clk_i(clk), .rst_ni(rst_n), .start_i(start11), .a_i(a11),
    .busy_o(busy11), .done_o(done11), .f_o(f11), .ovf_o(ovf11)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance to the next cycle and settle 1ns past the rising edge.
  task automatic stepCycle();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) stepCycle();
    rst_n = 1'b1;
    repeat (2) stepCycle();
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({busy22, done22, f22, ovf22} !== 19'd0)
      $display("[TB] FAIL reset22: got busy=%b done=%b f=%0d ovf=%b required all 0", busy22, done22, $signed(f22), ovf22);
    else passes++;
    checks++;
    if ({busy31, done31, f31, ovf31} !== 19'd0)
      $display("[TB] FAIL reset31: got busy=%b done=%b f=%0d ovf=%b required all 0", busy31, done31, $signed(f31), ovf31);
    else passes++;
    checks++;
    if ({busy11, done11, f11, ovf11} !== 19'd0)
      $display("[TB] FAIL reset11: got busy=%b done=%b f=%0d ovf=%b required all 0", busy11, done11, $signed(f11), ovf11);
    else passes++;
    #2 rst_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      stepCycle();
      checks++;
      if (busy22 !== 1'b0 || done22 !== 1'b0)
        $display("[TB] FAIL idle_quiet cycle %0d: got busy=%b done=%b required 0 0", k, busy22, done22);
      else passes++;
    end
  endtask

  task automatic test_basic_sum();
    a22[1][1] = 16'd100;
    a22[1][2] = -16'sd30;
    a22[2][1] = 16'd7;
    a22[2][2] = 16'd1;
    start22 = 1'b1;
    for (int k = 1; k <= 6; k++) begin
      stepCycle();
      start22 = 1'b0;
      if (k == 1) a22 = '0;
      checks++;
      if (busy22 !== (k <= 5))
        $display("[TB] FAIL basic_busy cycle %0d: got %b required %b", k, busy22, (k <= 5));
      else passes++;
      checks++;
      if (done22 !== (k == 5))
        $display("[TB] FAIL basic_done cycle %0d: got %b required %b", k, done22, (k == 5));
      else passes++;
      if (k == 5) begin
        checks++;
        if (f22 !== 16'd78 || ovf22 !== 1'b0)
          $display("[TB] FAIL basic_result: got f=%0d ovf=%b required f=78 ovf=0", $signed(f22), ovf22);
        else passes++;
      end
    end
  endtask

  task automatic test_saturation();
    for (int i = 0; i < 6; i++) begin
      for (int r = 1; r <= 2; r++)
        for (int c = 1; c <= 2; c++)
          a22[r][c] = 16'(satVec[i][(r-1)*2 + (c-1)]);
      start22 = 1'b1;
      stepCycle();
      start22 = 1'b0;
      repeat (4) stepCycle();
      checks++;
      if (done22 !== 1'b1 || f22 !== 16'(satExpF[i]) || ovf22 !== satExpOvf[i][0])
        $display("[TB] FAIL sat_vec%0d: got done=%b f=%0d ovf=%b required done=1 f=%0d ovf=%0d",
                 i, done22, $signed(f22), ovf22, satExpF[i], satExpOvf[i]);
      else passes++;
      stepCycle();
    end
  endtask

  task automatic test_snapshot_ignored_start();
    int doneCount;
    doneCount = 0;
    a31[1][1] = 16'd1;
    a31[2][1] = 16'd2;
    a31[3][1] = 16'd3;
    start31 = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      stepCycle();
      start31 = (k <= 2);
      if (k == 1) begin
        a31[1][1] = 16'd9;
        a31[2][1] = 16'd9;
        a31[3][1] = 16'd9;
      end
      if (done31 === 1'b1) doneCount++;
      if (k == 4) begin
        checks++;
        if (done31 !== 1'b1 || f31 !== 16'd6 || ovf31 !== 1'b0)
          $display("[TB] FAIL snapshot_result: got done=%b f=%0d ovf=%b required done=1 f=6 ovf=0", done31, $signed(f31), ovf31);
        else passes++;
      end
    end
    start31 = 1'b0;
    checks++;
    if (doneCount != 1)
      $display("[TB] FAIL snapshot_done_count: got %0d pulses required 1", doneCount);
    else passes++;
  endtask

  task automatic test_reset_mid_op();
    int doneCount;
    doneCount = 0;
    a31[1][1] = 16'd7;
    a31[2][1] = 16'd7;
    a31[3][1] = 16'd7;
    start31 = 1'b1;
    stepCycle();
    start31 = 1'b0;
    stepCycle();
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (busy31 !== 1'b0 || f31 !== 16'd0)
      $display("[TB] FAIL midreset_async: got busy=%b f=%0d required busy=0 f=0", busy31, $signed(f31));
    else passes++;
    #2 rst_n = 1'b1;
    for (int k = 0; k < 6; k++) begin
      stepCycle();
      if (done31 === 1'b1) doneCount++;
    end
    checks++;
    if (doneCount != 0 || f31 !== 16'd0)
      $display("[TB] FAIL midreset_no_done: got %0d pulses f=%0d required 0 pulses f=0", doneCount, $signed(f31));
    else passes++;
    a31[1][1] = 16'd4;
    a31[2][1] = 16'd5;
    a31[3][1] = 16'd6;
    start31 = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      stepCycle();
      start31 = 1'b0;
      checks++;
      if (done31 !== (k == 4))
        $display("[TB] FAIL midreset_restart_done cycle %0d: got %b required %b", k, done31, (k == 4));
      else passes++;
    end
    checks++;
    if (f31 !== 16'd15 || ovf31 !== 1'b0)
      $display("[TB] FAIL midreset_restart_result: got f=%0d ovf=%b required f=15 ovf=0", $signed(f31), ovf31);
    else passes++;
    stepCycle();
  endtask

  task automatic test_back_to_back();
    a11[1][1] = 16'd5;
    start11 = 1'b1;
    for (int k = 1; k <= 9; k++) begin
      stepCycle();
      checks++;
      if (done11 !== (k % 3 == 2))
        $display("[TB] FAIL b2b_done cycle %0d: got %b required %b", k, done11, (k % 3 == 2));
      else passes++;
      checks++;
      if (busy11 !== (k % 3 != 0))
        $display("[TB] FAIL b2b_busy cycle %0d: got %b required %b", k, busy11, (k % 3 != 0));
      else passes++;
      if (k % 3 == 2) begin
        checks++;
        if (f11 !== 16'd5 || ovf11 !== 1'b0)
          $display("[TB] FAIL b2b_result cycle %0d: got f=%0d ovf=%b required f=5 ovf=0", k, $signed(f11), ovf11);
        else passes++;
      end
    end
    start11 = 1'b0;
    repeat (3) stepCycle();
  endtask

  initial begin
    rst_n   = 1'b1;
    start22 = 1'b0;
    start31 = 1'b0;
    start11 = 1'b0;
    a22     = '0;
    a31     = '0;
    a11     = '0;
    test_reset();
    test_basic_sum();
    test_saturation();
    test_snapshot_ignored_start();
    test_reset_mid_op();
    test_back_to_back();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
